// File: rtl/btn_event_arbiter_pkg.sv
// Shared defaults and encodings for the button event arbiter.
// The debounce lanes, the event interface and the top all import this package.
package btn_pkg;

  localparam int N_BTN_DEF        = 4;
  localparam int PRESCALER_DEF    = 2;
  localparam int STABLE_TICKS_DEF = 4;

  localparam int IDX_W = (N_BTN_DEF > 1) ? $clog2(N_BTN_DEF) : 1;
  localparam int CNT_W = $clog2(STABLE_TICKS_DEF + 1);

  // Event type encoding carried on evt_release.
  localparam logic EVT_PRESS   = 1'b0;
  localparam logic EVT_RELEASE = 1'b1;

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Event stream channel from the arbiter to the consumer.
// Valid/ready: a transfer happens on a clk edge where evt_valid && evt_ready; while
// evt_valid && !evt_ready the producer holds evt_idx/evt_release stable, and the
// consumer may assert evt_ready at any time independently of evt_valid.
interface btn_event_arbiter_if
  import btn_pkg::*;
#(
  parameter int IDX_W = btn_pkg::IDX_W
);

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_release;

  modport master (
    output evt_valid,
    output evt_idx,
    output evt_release,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_idx,
    input  evt_release,
    output evt_ready
  );

endinterface

// File: rtl/btn_event_arbiter_lane.sv
// One debounce lane: 2-flop synchroniser, tick-driven stability counter,
// debounced state bit and a one-cycle flip strobe registered with the state.
module btn_debounce_lane
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int LANE_CNT_W   = CNT_W
)(
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic flip
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic [LANE_CNT_W-1:0] r_cnt;
  logic                  r_state;
  logic                  r_flip;

  localparam logic [LANE_CNT_W-1:0] CNT_LAST = LANE_CNT_W'(STABLE_TICKS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_flip  <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_flip  <= 1'b0;
      if (tick) begin
        if (r_sync2 != r_state) begin
          // The tick that would take the count to STABLE_TICKS flips instead.
          if (r_cnt == CNT_LAST) begin
            r_state <= ~r_state;
            r_cnt   <= '0;
            r_flip  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign state = r_state;
  assign flip  = r_flip;

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces N buttons, records press/release per lane in a pending register and
// serialises pending events round-robin into a single valid/ready event slot.
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int PRESCALER    = PRESCALER_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BTN-1:0]     btn_in,
  output logic [N_BTN-1:0]     btn_state,
  output logic                 overflow,
  btn_event_arbiter_if.master  evt
);

  localparam int SEL_W      = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int PS_W       = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam int LANE_CNT_W = $clog2(STABLE_TICKS + 1);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALER - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_BTN - 1);

  // Prescaler: with PRESCALER=1 the count sits at 0 and tick is always high.
  logic [PS_W-1:0] r_ps_cnt;
  logic            w_tick;

  assign w_tick = (r_ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps_cnt <= '0;
    end else if (w_tick) begin
      r_ps_cnt <= '0;
    end else begin
      r_ps_cnt <= r_ps_cnt + 1'b1;
    end
  end

  logic [N_BTN-1:0] w_state;
  logic [N_BTN-1:0] w_flip;

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    btn_debounce_lane #(
      .STABLE_TICKS (STABLE_TICKS),
      .LANE_CNT_W   (LANE_CNT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick),
      .raw   (btn_in[g]),
      .state (w_state[g]),
      .flip  (w_flip[g])
    );
  end

  assign btn_state = w_state;

  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_type;
  logic [SEL_W-1:0] r_rr;
  logic             r_valid;
  logic [SEL_W-1:0] r_idx;
  logic             r_rel;
  logic             r_ovf;

  logic             w_load;
  logic             w_any;
  logic             w_take;
  logic [SEL_W-1:0] w_sel;
  logic [SEL_W-1:0] w_rr_next;
  logic [N_BTN-1:0] w_grant;

  assign w_load = !r_valid || evt.evt_ready;

  // First pending lane at or above r_rr, wrapping past N_BTN-1.
  always_comb begin
    int j;
    j     = 0;
    w_any = 1'b0;
    w_sel = '0;
    for (int k = 0; k < N_BTN; k++) begin
      j = int'(r_rr) + k;
      if (j >= N_BTN) begin
        j = j - N_BTN;
      end
      if (!w_any && r_pend[j]) begin
        w_any = 1'b1;
        w_sel = SEL_W'(j);
      end
    end
  end

  assign w_take    = w_load && w_any;
  assign w_rr_next = (w_sel == SEL_LAST) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_grant = '0;
    if (w_take) begin
      w_grant[w_sel] = 1'b1;
    end
  end

  // A flip on a lane being granted in the same cycle keeps it pending with the
  // new type; the slot takes the older type, and that is not an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_type <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= |(w_flip & r_pend & ~w_grant);
      for (int i = 0; i < N_BTN; i++) begin
        if (w_flip[i]) begin
          r_pend[i] <= 1'b1;
          r_type[i] <= w_state[i] ? EVT_PRESS : EVT_RELEASE;
        end else if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_rel   <= 1'b0;
      r_rr    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_idx   <= w_sel;
        r_rel   <= r_type[w_sel];
        r_rr    <= w_rr_next;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt.evt_valid   = r_valid;
  assign evt.evt_idx     = r_idx;
  assign evt.evt_release = r_rel;
  assign overflow        = r_ovf;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: N_BTN=4, PRESCALER=2, STABLE_TICKS=4.
// Expected events are queued by the stimulus and popped by a separate monitor.
module tb_btn_event_arbiter;

  localparam int N_BTN        = 4;
  localparam int PRESCALER    = 2;
  localparam int STABLE_TICKS = 4;
  localparam int IDX_W        = 2;
  localparam int EW           = IDX_W + 1;
  localparam int LAT_MIN      = 9;
  localparam int LAT_MAX      = 2 + STABLE_TICKS * PRESCALER + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BTN-1:0] btn_in = '0;
  logic [N_BTN-1:0] btn_state;
  logic             overflow;

  btn_event_arbiter_if #(.IDX_W(IDX_W)) evt_if ();

  btn_event_arbiter #(
    .N_BTN        (N_BTN),
    .PRESCALER    (PRESCALER),
    .STABLE_TICKS (STABLE_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_state (btn_state),
    .overflow  (overflow),
    .evt       (evt_if)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            ovf_cnt  = 0;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_evt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  function automatic logic [EW-1:0] mk_evt(input int idx, input logic rel);
    mk_evt = {IDX_W'(idx), rel};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = {evt_if.evt_idx, evt_if.evt_release};
      if (prev_stall) begin
        check("hold_stable", 32'({evt_if.evt_valid, cur}), 32'({1'b1, prev_evt}));
      end
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: got idx %0d rel %0d expected no event",
                   evt_if.evt_idx, evt_if.evt_release);
        end else begin
          e = exp_q.pop_front();
          check("event", 32'(cur), 32'(e));
        end
      end
      prev_stall = evt_if.evt_valid && !evt_if.evt_ready;
      prev_evt   = cur;
      if (overflow) ovf_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N_BTN-1:0] b);
    rst_n  = 1'b0;
    btn_in = b;
    cyc(3);
    rst_n  = 1'b1;
  endtask

  task automatic pulse_ready();
    evt_if.evt_ready = 1'b1;
    cyc(1);
    evt_if.evt_ready = 1'b0;
    cyc(3);
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      cyc(1);
      c++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic state_latency(input string name, input int bit_i);
    int lat;
    lat = 0;
    while (!btn_state[bit_i] && lat < 20) begin
      cyc(1);
      lat++;
    end
    check_range(name, lat, LAT_MIN, LAT_MAX);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic saw_valid;
    logic saw_state;
    evt_if.evt_ready = 1'b1;
    rst_n  = 1'b0;
    btn_in = 4'b1111;

    // 1. reset with all buttons held, then four press events in index order
    repeat (3) begin
      @(negedge clk);
      check("rst_state", 32'(btn_state), 32'd0);
      check("rst_valid", 32'(evt_if.evt_valid), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_BTN; i++) exp_q.push_back(mk_evt(i, 1'b0));
    rst_n = 1'b1;
    drain("s1_press_all", 60);
    for (int i = 0; i < N_BTN; i++) exp_q.push_back(mk_evt(i, 1'b1));
    btn_in = 4'b0000;
    drain("s1_release_all", 60);
    check("s1_state_low", 32'(btn_state), 32'd0);

    // 2. single press and release
    exp_q.push_back(mk_evt(0, 1'b0));
    btn_in[0] = 1'b1;
    state_latency("s2_press_latency", 0);
    cyc(20);
    drain("s2_press", 10);
    exp_q.push_back(mk_evt(0, 1'b1));
    btn_in[0] = 1'b0;
    cyc(30);
    drain("s2_release", 10);
    check("s2_state", 32'(btn_state), 32'd0);

    // 3. a 5-cycle glitch never reaches btn_state
    btn_in[1] = 1'b1;
    cyc(5);
    btn_in[1] = 1'b0;
    saw_valid = 1'b0;
    saw_state = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (evt_if.evt_valid) saw_valid = 1'b1;
      if (btn_state[1]) saw_state = 1'b1;
    end
    check("s3_glitch_state", 32'(saw_state), 32'd0);
    check("s3_glitch_valid", 32'(saw_valid), 32'd0);

    // 4. round-robin under backpressure
    do_reset(4'b0000);
    evt_if.evt_ready = 1'b0;
    btn_in = 4'b1101;
    cyc(20);
    check("s4_valid", 32'(evt_if.evt_valid), 32'd1);
    check("s4_first_idx", 32'(evt_if.evt_idx), 32'd0);
    exp_q.push_back(mk_evt(0, 1'b0));
    exp_q.push_back(mk_evt(2, 1'b0));
    exp_q.push_back(mk_evt(3, 1'b0));
    repeat (3) pulse_ready();
    check("s4_empty_after", 32'(evt_if.evt_valid), 32'd0);
    check("s4_q1", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_q.push_back(mk_evt(0, 1'b1));
    exp_q.push_back(mk_evt(2, 1'b1));
    exp_q.push_back(mk_evt(3, 1'b1));
    btn_in = 4'b0000;
    cyc(20);
    repeat (3) pulse_ready();
    check("s4_q2", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_q.push_back(mk_evt(0, 1'b0));
    exp_q.push_back(mk_evt(1, 1'b0));
    btn_in = 4'b0011;
    cyc(20);
    repeat (2) pulse_ready();
    check("s4_q3", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // 5. overwrite of a pending event pulses overflow once
    do_reset(4'b0000);
    evt_if.evt_ready = 1'b0;
    btn_in = 4'b0001;
    cyc(15);
    check("s5_slot_idx", 32'({evt_if.evt_valid, evt_if.evt_idx}), 32'({1'b1, 2'd0}));
    ovf_cnt = 0;
    btn_in = 4'b0011;
    cyc(15);
    check("s5_no_ovf_yet", 32'(ovf_cnt), 32'd0);
    btn_in = 4'b0001;
    cyc(15);
    check("s5_ovf_once", 32'(ovf_cnt), 32'd1);
    exp_q.push_back(mk_evt(0, 1'b0));
    exp_q.push_back(mk_evt(1, 1'b1));
    repeat (2) pulse_ready();
    check("s5_q", 32'(exp_q.size()), 32'd0);
    check("s5_idle", 32'(evt_if.evt_valid), 32'd0);
    exp_q.delete();

    // 6. asynchronous reset with a held event and lane 2 mid-count
    btn_in = 4'b1001;
    cyc(15);
    check("s6_slot", 32'({evt_if.evt_valid, evt_if.evt_idx}), 32'({1'b1, 2'd3}));
    btn_in = 4'b1101;
    cyc(5);
    #3;
    rst_n  = 1'b0;
    btn_in = 4'b0100;
    #1;
    check("s6_async_valid", 32'(evt_if.evt_valid), 32'd0);
    check("s6_async_state", 32'(btn_state), 32'd0);
    cyc(2);
    evt_if.evt_ready = 1'b1;
    exp_q.push_back(mk_evt(2, 1'b0));
    rst_n = 1'b1;
    state_latency("s6_fresh_latency", 2);
    drain("s6_fresh_event", 10);
    cyc(20);
    check("s6_no_stale", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
Multi-button front end that debounces N raw button inputs, detects press/release transitions and serialises them into a single event stream over a valid/ready handshake. All lanes share one prescaler tick. A round-robin arbiter grants pending events to the consumer so no button starves. It sits between the board push-buttons and the control FSM, and replaces per-button debounce instances plus ad-hoc edge detection.

Parameters:
N_BTN, 4, number of button inputs (2..16)
PRESCALER, 2, clk cycles per debounce tick (>=1)
STABLE_TICKS, 4, consecutive ticks an input must differ from the debounced state before that state flips (>=1)
IDX_W, $clog2(N_BTN), width of the event index

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_in  input  N_BTN  raw, asynchronous button levels (1 = pressed)
btn_state  output  N_BTN  debounced levels
evt_valid  output  1  event slot holds an event
evt_ready  input  1  consumer accepts the event this cycle
evt_idx  output  IDX_W  button index of the event
evt_release  output  1  0 = press event, 1 = release event
overflow  output  1  one-cycle pulse: a pending event was overwritten before it was delivered

Behaviour:
- Reset (rst_n=0, async): sync flops, prescaler, lane counters, btn_state, pending bits, evt_valid, evt_idx, evt_release, overflow and the round-robin pointer all clear to 0. All registers also release on rst_n deassertion at the next clk edge.
- Sync: each btn_in bit passes through a 2-flop synchroniser.
- Prescaler: counts 0..PRESCALER-1. tick=1 for one cycle when count==PRESCALER-1, then the count wraps to 0. With PRESCALER=1, tick is constant 1.
- Lane counter, per button, updated only on tick:
  - If the synced input != btn_state, the counter increments.
  - If the synced input == btn_state, the counter clears.
  - When the counter reaches STABLE_TICKS-1 and the input still differs, btn_state toggles, the counter clears, and a flip strobe fires for one cycle.
  - Glitches shorter than STABLE_TICKS ticks never change btn_state.
- Pending register: per button, 1 pending bit plus 1 type bit (type=1 for release).
  - A flip sets pending and sets type to the new direction.
  - If pending is already set, the type is overwritten and overflow pulses for 1 cycle.
- Output slot load condition: evt_valid==0, or evt_valid&&evt_ready in the same cycle.
  - If any pending bit is set, the arbiter picks the first set bit searching upward, cyclically, from rr_ptr.
  - On load: evt_idx/evt_release load from the chosen button, its pending bit clears, rr_ptr becomes idx+1 (wrapping N_BTN-1 to 0), and evt_valid=1.
  - If nothing is pending, evt_valid goes to 0.
- Handshake:
  - evt_idx and evt_release stay stable while evt_valid && !evt_ready.
  - Back-to-back delivery runs at 1 event per cycle while ready is held high.
- Flip vs load in the same cycle on the same button: the flip wins, pending stays set with the new type, and the loaded event is the old one. overflow does not pulse.
- Latency: a stable raw change reaches btn_state after 2 sync cycles plus STABLE_TICKS ticks, i.e. at most 2 + STABLE_TICKS*PRESCALER + 1 cycles. evt_valid asserts 1 cycle after the flip when the slot is free.
- Reset mid-debounce or with evt_valid high: the event is lost and no event is emitted after reset.

Decomposition:
- Package btn_pkg:
  - Default N_BTN, PRESCALER, STABLE_TICKS.
  - Localparams IDX_W and CNT_W = $clog2(STABLE_TICKS+1).
  - Encoding constants EVT_PRESS=0 and EVT_RELEASE=1.
- Sub-module btn_debounce_lane:
  - Contains the synchroniser, lane counter, btn_state bit and flip strobe.
  - Inputs: clk, rst_n, tick, raw. Outputs: state, flip.
  - Instantiated N_BTN times in a generate loop.
  - The prescaler, pending register, arbiter and output slot stay in the top module.

Test Plan:
All scenarios use N_BTN=4, PRESCALER=2, STABLE_TICKS=4, 10 ns clk.
1. Reset: hold rst_n=0 for 3 cycles with btn_in=4'b1111 -> btn_state=0, evt_valid=0 and overflow=0 throughout. Release rst_n, hold evt_ready=1 and btn_in=4'b1111 -> events idx 0,1,2,3 all with release=0, in order.
2. Press and release, evt_ready=1: btn_in[0]=1 for 30 cycles -> btn_state[0] rises within 11 cycles, then exactly 1 event (idx=0, release=0). btn_in[0]=0 -> 1 event (idx=0, release=1).
3. Glitch rejection: btn_in[1]=1 for 5 cycles, then 0 -> btn_state[1] stays 0, evt_valid never asserts.
4. Round-robin under backpressure: evt_ready=0, press buttons 0, 2 and 3 together -> evt_valid holds idx=0 stable. Pulse evt_ready for 1 cycle three times -> idx sequence 0, 2, 3. Then press button 1 and button 0 -> next grants are 0, then 1 (rr_ptr=0 after idx 3).
5. Overflow: with evt_ready=0 and the slot occupied by button 0, press then release button 1 -> overflow pulses exactly once. On the ready pulses, the button 1 event delivered has release=1.
6. Async reset mid-operation: assert rst_n=0 asynchronously (between clk edges) while evt_valid=1 and lane 2 is mid-count -> evt_valid=0 immediately. No stale event appears after reset, and with btn_in[2] still high, a fresh press event arrives after the full debounce latency.
